traffic_phase_sequencer: RTL and testbench

Single-clock intersection phase sequencer. It decides which approach (North or East) holds the shared intersection, and when a pedestrian walk interval is inserted. Car sensors and the pedestrian button are latched as pending requests and served in alternating order with minimum-green, yellow and all-red guarantees. It runs from CLOCK_50 with a one-cycle 1 Hz `tick` enable, not a derived clock, and drives the active-low lamp outputs plus a seconds-remaining value for the display mux.

---
 rtl/traffic_phase_sequencer_if.sv | 27 ++
 rtl/traffic_phase_sequencer.sv | 120 ++++++++++++
 tb/tb_traffic_phase_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_sequencer_if.sv
// Signal bundle for traffic_phase_sequencer: tick/sensor inputs, lamps and status outputs.
interface traffic_phase_sequencer_if;
    logic       tick;
    logic       sN;
    logic       sE;
    logic       ped_req;
    logic       GN;
    logic       YN;
    logic       RN;
    logic       GE;
    logic       YE;
    logic       RE;
    logic       walk;
    logic [2:0] phase;
    logic [5:0] remain;
    logic       ped_pending;

    modport master (
        output tick, sN, sE, ped_req,
        input  GN, YN, RN, GE, YE, RE, walk, phase, remain, ped_pending
    );

    modport slave (
        input  tick, sN, sE, ped_req,
        output GN, YN, RN, GE, YE, RE, walk, phase, remain, ped_pending
    );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Two-approach intersection phase sequencer driven by a 1 Hz tick enable.
// Define PED_WALK_EN to enable the pedestrian latch, walk phase and walk lamp.
module traffic_phase_sequencer #(
    parameter int unsigned MIN_GREEN = 10,
    parameter int unsigned YELLOW_T  = 5,
    parameter int unsigned ALLRED_T  = 2,
    parameter int unsigned WALK_T    = 15
) (
    input logic                     CLOCK_50,
    input logic                     reset,
    traffic_phase_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        StGn   = 3'd0,
        StYn   = 3'd1,
        StAr1  = 3'd2,
        StGe   = 3'd3,
        StYe   = 3'd4,
        StAr2  = 3'd5,
        StWalk = 3'd6
    } state_e;

    localparam logic [5:0] MinGreen = 6'(MIN_GREEN);
    localparam logic [5:0] YellowT  = 6'(YELLOW_T);
    localparam logic [5:0] AllRedT  = 6'(ALLRED_T);
    localparam logic [5:0] WalkT    = 6'(WALK_T);

    state_e     state_q, state_d;
    logic [5:0] elapsed_q, elapsed_d, elapsed_inc;
    logic       n_pend_q, n_pend_d;
    logic       e_pend_q, e_pend_d;
    logic       p_pend_q;
    logic       next_dir_q, next_dir_d;  // 1 = East, 0 = North
    logic       entering;
    logic [5:0] duration;

    always_comb begin
        elapsed_inc = (elapsed_q == 6'd63) ? 6'd63 : elapsed_q + 6'd1;
        state_d     = state_q;
        unique case (state_q)
            StGn:   if (bus.tick && elapsed_inc >= MinGreen && (e_pend_q || p_pend_q))
                        state_d = StYn;
            StYn:   if (bus.tick && elapsed_inc == YellowT) state_d = StAr1;
            StAr1:  if (bus.tick && elapsed_inc == AllRedT) state_d = p_pend_q ? StWalk : StGe;
            StGe:   if (bus.tick && elapsed_inc >= MinGreen && (n_pend_q || p_pend_q))
                        state_d = StYe;
            StYe:   if (bus.tick && elapsed_inc == YellowT) state_d = StAr2;
            StAr2:  if (bus.tick && elapsed_inc == AllRedT) state_d = p_pend_q ? StWalk : StGn;
            StWalk: if (bus.tick && elapsed_inc == WalkT) state_d = next_dir_q ? StGe : StGn;
            default: state_d = StGn;  // illegal code 7 recovers without waiting for tick
        endcase

        entering   = (state_d != state_q);
        elapsed_d  = entering ? 6'd0 : (bus.tick ? elapsed_inc : elapsed_q);
        // Clear beats set: a request arriving on the serving entry is already being served.
        n_pend_d   = (entering && state_d == StGn) ? 1'b0 : (n_pend_q | bus.sN);
        e_pend_d   = (entering && state_d == StGe) ? 1'b0 : (e_pend_q | bus.sE);
        next_dir_d = next_dir_q;
        if (entering && state_d == StAr1) next_dir_d = 1'b1;
        if (entering && state_d == StAr2) next_dir_d = 1'b0;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q    <= StGn;
            elapsed_q  <= 6'd0;
            n_pend_q   <= 1'b0;
            e_pend_q   <= 1'b0;
            next_dir_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            elapsed_q  <= elapsed_d;
            n_pend_q   <= n_pend_d;
            e_pend_q   <= e_pend_d;
            next_dir_q <= next_dir_d;
        end
    end

`ifdef PED_WALK_EN
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            p_pend_q <= 1'b0;
        end else if (entering && state_d == StWalk) begin
            p_pend_q <= 1'b0;
        end else begin
            p_pend_q <= p_pend_q | bus.ped_req;
        end
    end
    assign bus.walk = (state_q == StWalk);
`else
    assign p_pend_q = 1'b0;
    assign bus.walk = 1'b0;
`endif

    assign bus.ped_pending = p_pend_q;
    assign bus.phase       = state_q;

    always_comb begin
        bus.GN   = 1'b1;
        bus.YN   = 1'b1;
        bus.RN   = 1'b1;
        bus.GE   = 1'b1;
        bus.YE   = 1'b1;
        bus.RE   = 1'b1;
        duration = 6'd0;
        unique case (state_q)
            StGn:   begin bus.GN = 1'b0; bus.RE = 1'b0; duration = MinGreen; end
            StYn:   begin bus.YN = 1'b0; bus.RE = 1'b0; duration = YellowT;  end
            StAr1:  begin bus.RN = 1'b0; bus.RE = 1'b0; duration = AllRedT;  end
            StGe:   begin bus.GE = 1'b0; bus.RN = 1'b0; duration = MinGreen; end
            StYe:   begin bus.YE = 1'b0; bus.RN = 1'b0; duration = YellowT;  end
            StAr2:  begin bus.RN = 1'b0; bus.RE = 1'b0; duration = AllRedT;  end
            StWalk: begin bus.RN = 1'b0; bus.RE = 1'b0; duration = WalkT;    end
            default: begin bus.RN = 1'b0; bus.RE = 1'b0; end
        endcase
        bus.remain = (elapsed_q >= duration) ? 6'd0 : duration - elapsed_q;
    end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed self-checking bench for traffic_phase_sequencer (default parameters).
module tb_traffic_phase_sequencer;

    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    traffic_phase_sequencer_if bus ();

    traffic_phase_sequencer dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) bus.tick = 1'b1;
            @(negedge clk) bus.tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_sn();
        @(negedge clk) bus.sN = 1'b1;
        @(negedge clk) bus.sN = 1'b0;
    endtask

    task automatic pulse_se();
        @(negedge clk) bus.sE = 1'b1;
        @(negedge clk) bus.sE = 1'b0;
    endtask

    task automatic check_lamps(input string tag, input logic [5:0] exp_gyr);
        // order: GN YN RN GE YE RE
        check(tag, {26'd0, bus.GN, bus.YN, bus.RN, bus.GE, bus.YE, bus.RE}, {26'd0, exp_gyr});
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        reset       = 1'b0;
        bus.tick    = 1'b0;
        bus.sN      = 1'b0;
        bus.sE      = 1'b0;
        bus.ped_req = 1'b0;

        // Reset values; a tick during reset is ignored
        #2 reset = 1'b1;
        #1;
        check("rst_phase", bus.phase, 0);
        check_lamps("rst_lamps", 6'b011110);
        check("rst_walk", bus.walk, 0);
        check("rst_remain", bus.remain, 10);
        check("rst_ped", bus.ped_pending, 0);
        @(negedge clk) bus.tick = 1'b1;
        @(negedge clk) bus.tick = 1'b0;
        check("rst_tick_ignored", bus.remain, 10);
        @(negedge clk) reset = 1'b0;

        // No requests: green holds, remain counts down then saturates
        for (int k = 1; k <= 40; k++) begin
            tick_n(1);
            check("idle_remain", bus.remain, (k >= 10) ? 0 : 10 - k);
        end
        check("idle_phase", bus.phase, 0);
        check_lamps("idle_lamps", 6'b011110);

        // East request before tick 3 of a fresh green
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        tick_n(2);
        pulse_se();
        tick_n(7);
        check("gn_hold_t9", bus.phase, 0);
        check("gn_remain_t9", bus.remain, 1);
        tick_n(1);
        check("yn_phase", bus.phase, 1);
        check("yn_remain", bus.remain, 5);
        check_lamps("yn_lamps", 6'b101110);
        tick_n(4);
        check("yn_hold", bus.phase, 1);
        tick_n(1);
        check("ar1_phase", bus.phase, 2);
        check("ar1_remain", bus.remain, 2);
        check_lamps("ar1_lamps", 6'b110110);
        tick_n(1);
        check("ar1_hold", bus.phase, 2);
        tick_n(1);
        check("ge_phase", bus.phase, 3);
        check("ge_remain", bus.remain, 10);
        check_lamps("ge_lamps", 6'b110011);

        // North request in GE, ped_req held high (ignored unless walk build)
        bus.ped_req = 1'b1;
        tick_n(2);
        pulse_sn();
`ifndef PED_WALK_EN
        tick_n(7);
        check("ge_hold_t9", bus.phase, 3);
        check("ge_no_ped", bus.ped_pending, 0);
        tick_n(1);
        check("ye_phase", bus.phase, 4);
        check_lamps("ye_lamps", 6'b110101);
        check("ye_walk", bus.walk, 0);
        tick_n(5);
        check("ar2_phase", bus.phase, 5);
        check_lamps("ar2_lamps", 6'b110110);
        tick_n(2);
        check("gn2_phase", bus.phase, 0);
        check("gn2_remain", bus.remain, 10);
        check("gn2_walk", bus.walk, 0);
        bus.ped_req = 1'b0;

        // e_pend was cleared on GE entry: green holds past the minimum
        tick_n(20);
        check("e_pend_cleared", bus.phase, 0);

        // Request coinciding with tick 21 is seen only at tick 22
        @(negedge clk) begin bus.tick = 1'b1; bus.sE = 1'b1; end
        @(negedge clk) begin bus.tick = 1'b0; bus.sE = 1'b0; end
        @(negedge clk);
        check("late_req_t21", bus.phase, 0);
        tick_n(1);
        check("late_req_t22", bus.phase, 1);
        check("late_req_remain", bus.remain, 5);

        // Walk to YE elapsed 3, then asynchronous reset drops everything
        tick_n(7);
        check("to_ge", bus.phase, 3);
        pulse_sn();
        tick_n(10);
        check("to_ye", bus.phase, 4);
        tick_n(3);
        check("ye_e3_remain", bus.remain, 2);
        pulse_se();
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_rst_phase", bus.phase, 0);
        check("async_rst_remain", bus.remain, 10);
        check_lamps("async_rst_lamps", 6'b011110);
        @(negedge clk) reset = 1'b0;
        tick_n(1);
        check("post_rst_remain", bus.remain, 9);
        tick_n(11);
        check("post_rst_no_pend", bus.phase, 0);
`else
        check("ped_latched", bus.ped_pending, 1);
        bus.ped_req = 1'b0;
        tick_n(8);
        check("ge_to_ye", bus.phase, 4);
        tick_n(5);
        check("ar2_phase", bus.phase, 5);
        tick_n(2);
        check("walk_phase", bus.phase, 6);
        check("walk_lamp", bus.walk, 1);
        check("walk_ped_clr", bus.ped_pending, 0);
        check("walk_remain", bus.remain, 15);
        check_lamps("walk_lamps", 6'b110110);
        tick_n(14);
        check("walk_hold", bus.phase, 6);
        tick_n(1);
        check("walk_to_gn", bus.phase, 0);
        check("walk_off", bus.walk, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
